ecies_top: RTL and testbench



---
 rtl/ecies_pkg.sv | 49 ++++
 rtl/ecies_decrypter.sv | 103 ++++++++++
 rtl/ecies_top.sv | 162 ++++++++++++++++
 tb/tb_ecies_top.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecies_pkg.sv
// Shared widths, state encodings and ciphertext record layout for the ECIES sequencer.
package ecies_pkg;

    localparam int unsigned message_width  = 32;
    localparam int unsigned hashed_width   = 512;
    localparam int unsigned key_size       = 128;
    localparam int unsigned mac_key_length = 256;
    localparam int unsigned enc_key_len    = 128;
    localparam int unsigned dec_key_len    = 128;
    localparam int unsigned integer_size   = 64;

    localparam int unsigned KDF_TAG_W = 16;
    localparam int unsigned KDF_REQ_W = KDF_TAG_W + integer_size;
    localparam logic [KDF_TAG_W-1:0] KDF_TAG = 16'h0001;

    // KDF digest split: low 128 bits feed AES, the next 256 bits are the MAC key
    localparam int unsigned AES_KEY_LO = 0;
    localparam int unsigned AES_KEY_HI = AES_KEY_LO + enc_key_len - 1;
    localparam int unsigned MAC_KEY_LO = AES_KEY_HI + 1;
    localparam int unsigned MAC_KEY_HI = MAC_KEY_LO + mac_key_length - 1;

    typedef enum logic [2:0] {
        ENC_IDLE,
        ENC_KDF,
        ENC_AES,
        ENC_MAC,
        ENC_DONE
    } enc_state_t;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_KDF,
        DEC_MAC,
        DEC_AES,
        DEC_DONE
    } dec_state_t;

    typedef struct packed {
        logic [message_width-1:0] c;
        logic [integer_size-1:0]  rx;
        logic [integer_size-1:0]  ry;
        logic [hashed_width-1:0]  tag;
    } cipher_rec_t;

    function automatic logic [KDF_REQ_W-1:0] kdf_req(input logic [integer_size-1:0] rx);
        return {KDF_TAG, rx};
    endfunction

endpackage

// File: rtl/ecies_decrypter.sv
// Decrypter sequencer: KDF, MAC tag check against the stored record, then AES release.
module ecies_decrypter
    import ecies_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_go,
    input  logic                     i_cipher_valid,
    input  logic                     i_hash_ready,
    input  logic                     i_kdf_hash_done,
    input  logic [hashed_width-1:0]  i_kdf_hashed,
    input  logic                     i_hash_done,
    input  logic [hashed_width-1:0]  i_hashed_message,
    input  logic                     i_aes_done,
    input  logic [message_width-1:0] i_message_return,
    input  logic [message_width-1:0] i_rec_c,
    input  logic [integer_size-1:0]  i_rec_rx,
    input  logic [hashed_width-1:0]  i_rec_tag,
    output logic                     o_kdf_hash_go,
    output logic [KDF_REQ_W-1:0]     o_kdf_req,
    output logic                     o_hash_go,
    output logic                     o_aes_go,
    output logic [message_width-1:0] o_msg_to_process,
    output logic [message_width-1:0] o_message_output,
    output logic [dec_key_len-1:0]   o_key,
    output logic                     o_kdf_done,
    output logic                     o_ready,
    output logic                     o_done,
    output logic                     o_valid
);

    dec_state_t                r_state;
    logic [dec_key_len-1:0]    r_key;
    logic [mac_key_length-1:0] r_mac_key;
    logic                      r_kdf_done;
    logic                      r_tag_ok;
    logic [message_width-1:0]  r_msg_out;
    logic                      w_tag_match;
    logic                      w_unused;

    assign w_tag_match = (i_hashed_message == i_rec_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= DEC_IDLE;
            r_key      <= '0;
            r_mac_key  <= '0;
            r_kdf_done <= 1'b0;
            r_tag_ok   <= 1'b0;
            r_msg_out  <= '0;
        end else if (r_state != DEC_IDLE && !i_go) begin
            r_state <= DEC_IDLE;
        end else begin
            case (r_state)
                DEC_IDLE: begin
                    r_kdf_done <= 1'b0;
                    // Without a stored record there is nothing to decrypt
                    if (i_go && i_cipher_valid) begin
                        r_state <= DEC_KDF;
                    end
                end
                DEC_KDF: begin
                    if (i_kdf_hash_done) begin
                        r_key      <= i_kdf_hashed[AES_KEY_HI:AES_KEY_LO];
                        r_mac_key  <= i_kdf_hashed[MAC_KEY_HI:MAC_KEY_LO];
                        r_kdf_done <= 1'b1;
                        r_state    <= DEC_MAC;
                    end
                end
                DEC_MAC: begin
                    if (i_hash_done) begin
                        r_tag_ok <= w_tag_match;
                        r_state  <= w_tag_match ? DEC_AES : DEC_DONE;
                    end
                end
                DEC_AES: begin
                    if (i_aes_done) begin
                        r_msg_out <= i_message_return;
                        r_state   <= DEC_DONE;
                    end
                end
                DEC_DONE: r_state <= DEC_DONE;
                default:  r_state <= DEC_IDLE;
            endcase
        end
    end

    assign o_ready          = (r_state == DEC_IDLE);
    assign o_kdf_hash_go    = (r_state == DEC_KDF) && i_hash_ready;
    assign o_kdf_req        = (r_state == DEC_KDF) ? kdf_req(i_rec_rx) : '0;
    assign o_hash_go        = (r_state == DEC_MAC) && i_hash_ready;
    assign o_aes_go         = (r_state == DEC_AES);
    assign o_msg_to_process = (r_state == DEC_AES) ? i_rec_c : '0;
    assign o_message_output = r_msg_out;
    assign o_key            = r_key;
    assign o_kdf_done       = r_kdf_done;
    assign o_done           = (r_state == DEC_DONE);
    assign o_valid          = (r_state == DEC_DONE) && r_tag_ok;

    // MAC key is held for the external MAC path; not consumed inside this block
    assign w_unused = ^{i_kdf_hashed[hashed_width-1:MAC_KEY_HI+1], r_mac_key};

endmodule

// File: rtl/ecies_top.sv
// ECIES sequencer: encrypter FSM and ciphertext record, with the decrypter as a sub-block.
module ecies_top
    import ecies_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      encrypter_go,
    input  logic                      decrypter_go,
    input  logic                      hash_ready,
    input  logic                      enc_kdf_hashDone,
    input  logic                      dec_kdf_hashDone,
    input  logic [hashed_width-1:0]   encrypt_kdf_hashed,
    input  logic [hashed_width-1:0]   decrypt_kdf_hashed,
    input  logic                      enc_hash_done,
    input  logic                      dec_hash_done,
    input  logic [hashed_width-1:0]   enc_hashedMessage,
    input  logic [hashed_width-1:0]   dec_hashedMessage,
    input  logic                      enc_done,
    input  logic                      dec_done,
    input  logic [message_width-1:0]  message,
    input  logic [message_width-1:0]  enc_encryptedMessage,
    input  logic [message_width-1:0]  messageReturn,
    input  logic [key_size-1:0]       privateKey,
    input  logic [key_size-1:0]       counter,
    input  logic [key_size-1:0]       nonce,
    input  logic [key_size-1:0]       publicKeyX,
    input  logic [key_size-1:0]       publicKeyY,
    input  logic [integer_size-1:0]   prime,
    input  logic [integer_size-1:0]   A,
    input  logic [integer_size-1:0]   B,
    input  logic [integer_size-1:0]   Px,
    input  logic [integer_size-1:0]   Py,
    input  logic [integer_size-1:0]   n,
    output logic [KDF_REQ_W-1:0]      encrypt_kdf_req,
    output logic [KDF_REQ_W-1:0]      decrypt_kdf_req,
    output logic                      enc_kdf_hashGo,
    output logic                      dec_kdf_hashGo,
    output logic                      enc_hash_go,
    output logic                      dec_hash_go,
    output logic                      enc_go,
    output logic                      dec_go,
    output logic [message_width-1:0]  enc_messageToProcess,
    output logic [message_width-1:0]  dec_messageToProcess,
    output logic [message_width-1:0]  messageOutput,
    output logic [hashed_width-1:0]   hashedMessage,
    output logic [enc_key_len-1:0]    enc_key,
    output logic [dec_key_len-1:0]    dec_key,
    output logic                      enc_kdf_done,
    output logic                      dec_kdf_done,
    output logic                      key_done,
    output logic                      enc_ready,
    output logic                      dec_ready,
    output logic                      encrypter_done,
    output logic                      decrypter_done,
    output logic                      enc_valid,
    output logic                      dec_valid
);

    enc_state_t                r_enc_state;
    logic [enc_key_len-1:0]    r_enc_key;
    logic [mac_key_length-1:0] r_enc_mac_key;
    logic                      r_enc_kdf_done;
    cipher_rec_t               r_rec;
    logic                      r_cipher_valid;
    logic                      w_unused;

    // Encrypter FSM; also owns the ciphertext record consumed by the decrypter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_enc_state    <= ENC_IDLE;
            r_enc_key      <= '0;
            r_enc_mac_key  <= '0;
            r_enc_kdf_done <= 1'b0;
            r_rec          <= '0;
            r_cipher_valid <= 1'b0;
        end else if (r_enc_state != ENC_IDLE && !encrypter_go) begin
            r_enc_state <= ENC_IDLE;
        end else begin
            case (r_enc_state)
                ENC_IDLE: begin
                    r_enc_kdf_done <= 1'b0;
                    if (encrypter_go) begin
                        r_rec.rx    <= publicKeyX[integer_size-1:0];
                        r_rec.ry    <= publicKeyY[integer_size-1:0];
                        r_enc_state <= ENC_KDF;
                    end
                end
                ENC_KDF: begin
                    if (enc_kdf_hashDone) begin
                        r_enc_key      <= encrypt_kdf_hashed[AES_KEY_HI:AES_KEY_LO];
                        r_enc_mac_key  <= encrypt_kdf_hashed[MAC_KEY_HI:MAC_KEY_LO];
                        r_enc_kdf_done <= 1'b1;
                        r_enc_state    <= ENC_AES;
                    end
                end
                ENC_AES: begin
                    if (enc_done) begin
                        r_rec.c     <= enc_encryptedMessage;
                        r_enc_state <= ENC_MAC;
                    end
                end
                ENC_MAC: begin
                    if (enc_hash_done) begin
                        r_rec.tag      <= enc_hashedMessage;
                        r_cipher_valid <= 1'b1;
                        r_enc_state    <= ENC_DONE;
                    end
                end
                ENC_DONE: r_enc_state <= ENC_DONE;
                default:  r_enc_state <= ENC_IDLE;
            endcase
        end
    end

    assign enc_ready            = (r_enc_state == ENC_IDLE);
    assign enc_kdf_hashGo       = (r_enc_state == ENC_KDF) && hash_ready;
    assign encrypt_kdf_req      = (r_enc_state == ENC_KDF) ? kdf_req(r_rec.rx) : '0;
    assign enc_go               = (r_enc_state == ENC_AES);
    assign enc_messageToProcess = (r_enc_state == ENC_AES) ? message : '0;
    assign enc_hash_go          = (r_enc_state == ENC_MAC) && hash_ready;
    assign encrypter_done       = (r_enc_state == ENC_DONE);
    assign enc_valid            = (r_enc_state == ENC_DONE);
    assign enc_key              = r_enc_key;
    assign enc_kdf_done         = r_enc_kdf_done;
    assign hashedMessage        = r_rec.tag;
    assign key_done             = enc_kdf_done | dec_kdf_done;

    ecies_decrypter u_dec (
        .clk              (clk),
        .rst              (rst),
        .i_go             (decrypter_go),
        .i_cipher_valid   (r_cipher_valid),
        .i_hash_ready     (hash_ready),
        .i_kdf_hash_done  (dec_kdf_hashDone),
        .i_kdf_hashed     (decrypt_kdf_hashed),
        .i_hash_done      (dec_hash_done),
        .i_hashed_message (dec_hashedMessage),
        .i_aes_done       (dec_done),
        .i_message_return (messageReturn),
        .i_rec_c          (r_rec.c),
        .i_rec_rx         (r_rec.rx),
        .i_rec_tag        (r_rec.tag),
        .o_kdf_hash_go    (dec_kdf_hashGo),
        .o_kdf_req        (decrypt_kdf_req),
        .o_hash_go        (dec_hash_go),
        .o_aes_go         (dec_go),
        .o_msg_to_process (dec_messageToProcess),
        .o_message_output (messageOutput),
        .o_key            (dec_key),
        .o_kdf_done       (dec_kdf_done),
        .o_ready          (dec_ready),
        .o_done           (decrypter_done),
        .o_valid          (dec_valid)
    );

    // Key material and curve parameters pass through this block untouched
    assign w_unused = ^{privateKey, counter, nonce,
                        publicKeyX[key_size-1:integer_size], publicKeyY[key_size-1:integer_size],
                        prime, A, B, Px, Py, n, r_rec.ry,
                        encrypt_kdf_hashed[hashed_width-1:MAC_KEY_HI+1], r_enc_mac_key};

endmodule

// File: tb/tb_ecies_top.sv
// Directed bench for ecies_top: protocol-level model checked every cycle plus literal spot checks.
module tb_ecies_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         encrypter_go, decrypter_go, hash_ready;
    logic         enc_kdf_hashDone, dec_kdf_hashDone;
    logic [511:0] encrypt_kdf_hashed, decrypt_kdf_hashed;
    logic         enc_hash_done, dec_hash_done;
    logic [511:0] enc_hashedMessage, dec_hashedMessage;
    logic         enc_done, dec_done;
    logic [31:0]  message, enc_encryptedMessage, messageReturn;
    logic [127:0] privateKey, counter, nonce, publicKeyX, publicKeyY;
    logic [63:0]  prime, A, B, Px, Py, n;
    logic [79:0]  encrypt_kdf_req, decrypt_kdf_req;
    logic         enc_kdf_hashGo, dec_kdf_hashGo, enc_hash_go, dec_hash_go, enc_go, dec_go;
    logic [31:0]  enc_messageToProcess, dec_messageToProcess, messageOutput;
    logic [511:0] hashedMessage;
    logic [127:0] enc_key, dec_key;
    logic         enc_kdf_done, dec_kdf_done, key_done, enc_ready, dec_ready;
    logic         encrypter_done, decrypter_done, enc_valid, dec_valid;

    int total = 0;
    int bad   = 0;

    ecies_top dut (
        .clk(clk), .rst(rst), .encrypter_go(encrypter_go), .decrypter_go(decrypter_go),
        .hash_ready(hash_ready), .enc_kdf_hashDone(enc_kdf_hashDone), .dec_kdf_hashDone(dec_kdf_hashDone),
        .encrypt_kdf_hashed(encrypt_kdf_hashed), .decrypt_kdf_hashed(decrypt_kdf_hashed),
        .enc_hash_done(enc_hash_done), .dec_hash_done(dec_hash_done),
        .enc_hashedMessage(enc_hashedMessage), .dec_hashedMessage(dec_hashedMessage),
        .enc_done(enc_done), .dec_done(dec_done), .message(message),
        .enc_encryptedMessage(enc_encryptedMessage), .messageReturn(messageReturn),
        .privateKey(privateKey), .counter(counter), .nonce(nonce),
        .publicKeyX(publicKeyX), .publicKeyY(publicKeyY),
        .prime(prime), .A(A), .B(B), .Px(Px), .Py(Py), .n(n),
        .encrypt_kdf_req(encrypt_kdf_req), .decrypt_kdf_req(decrypt_kdf_req),
        .enc_kdf_hashGo(enc_kdf_hashGo), .dec_kdf_hashGo(dec_kdf_hashGo),
        .enc_hash_go(enc_hash_go), .dec_hash_go(dec_hash_go), .enc_go(enc_go), .dec_go(dec_go),
        .enc_messageToProcess(enc_messageToProcess), .dec_messageToProcess(dec_messageToProcess),
        .messageOutput(messageOutput), .hashedMessage(hashedMessage),
        .enc_key(enc_key), .dec_key(dec_key), .enc_kdf_done(enc_kdf_done), .dec_kdf_done(dec_kdf_done),
        .key_done(key_done), .enc_ready(enc_ready), .dec_ready(dec_ready),
        .encrypter_done(encrypter_done), .decrypter_done(decrypter_done),
        .enc_valid(enc_valid), .dec_valid(dec_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol model: each FSM is a position in its fixed step sequence, advanced by that step's handshake
    int           me = 0, md = 0;
    logic         m_live = 1'b0;
    logic         m_ekd, m_dkd, m_cv, m_ok;
    logic [127:0] m_ekey, m_dkey;
    logic [31:0]  m_c, m_out;
    logic [63:0]  m_rx;
    logic [511:0] m_tag;

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (!rst) begin
            me <= 0; md <= 0; m_ekd <= 1'b0; m_dkd <= 1'b0; m_cv <= 1'b0; m_ok <= 1'b0;
            m_ekey <= '0; m_dkey <= '0; m_c <= '0; m_out <= '0; m_rx <= '0; m_tag <= '0;
        end else begin
            if (me != 0 && !encrypter_go) me <= 0;
            else case (me)
                0: begin m_ekd <= 1'b0; if (encrypter_go) begin me <= 1; m_rx <= publicKeyX[63:0]; end end
                1: if (enc_kdf_hashDone) begin me <= 2; m_ekey <= encrypt_kdf_hashed[127:0]; m_ekd <= 1'b1; end
                2: if (enc_done) begin me <= 3; m_c <= enc_encryptedMessage; end
                3: if (enc_hash_done) begin me <= 4; m_tag <= enc_hashedMessage; m_cv <= 1'b1; end
                default: ;
            endcase
            if (md != 0 && !decrypter_go) md <= 0;
            else case (md)
                0: begin m_dkd <= 1'b0; if (decrypter_go && m_cv) md <= 1; end
                1: if (dec_kdf_hashDone) begin md <= 2; m_dkey <= decrypt_kdf_hashed[127:0]; m_dkd <= 1'b1; end
                2: if (dec_hash_done) begin
                       m_ok <= (dec_hashedMessage == m_tag);
                       md   <= (dec_hashedMessage == m_tag) ? 3 : 4;
                   end
                3: if (dec_done) begin md <= 4; m_out <= messageReturn; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("status",
                {enc_ready, dec_ready, enc_kdf_hashGo, dec_kdf_hashGo, enc_hash_go, dec_hash_go,
                 enc_go, dec_go, encrypter_done, decrypter_done, enc_valid, dec_valid,
                 enc_kdf_done, dec_kdf_done, key_done},
                {me == 0, md == 0, me == 1 && hash_ready, md == 1 && hash_ready,
                 me == 3 && hash_ready, md == 2 && hash_ready, me == 2, md == 3,
                 me == 4, md == 4, me == 4, md == 4 && m_ok, m_ekd, m_dkd, m_ekd | m_dkd});
            chk("keys", {enc_key, dec_key}, {m_ekey, m_dkey});
            chk("data", {messageOutput, enc_messageToProcess, dec_messageToProcess},
                {m_out, (me == 2) ? message : 32'h0, (md == 3) ? m_c : 32'h0});
            chk("tag", hashedMessage, m_tag);
            chk("kdf_req", {encrypt_kdf_req, decrypt_kdf_req},
                {(me == 1) ? {16'h0001, m_rx} : 80'h0, (md == 1) ? {16'h0001, m_rx} : 80'h0});
        end
    end

    localparam logic [79:0]  REQ    = 80'h0001_0000_0000_0000_0006;
    localparam logic [511:0] DIGEST = (512'h5 << 200) | 512'd300;

    initial begin
        rst = 1'b0; encrypter_go = 1'b0; decrypter_go = 1'b0; hash_ready = 1'b1;
        enc_kdf_hashDone = 1'b0; dec_kdf_hashDone = 1'b0; enc_hash_done = 1'b0; dec_hash_done = 1'b0;
        enc_done = 1'b0; dec_done = 1'b0;
        encrypt_kdf_hashed = DIGEST; decrypt_kdf_hashed = DIGEST;
        enc_hashedMessage = 512'd2; dec_hashedMessage = 512'd2;
        message = 32'd8; enc_encryptedMessage = 32'hC0DE_0008; messageReturn = 32'd8;
        // Curve y^2 = x^3 + 5 mod 7, P=(3,2), d=3 -> Q = 3P = (6,5)
        prime = 64'd7; A = 64'd0; B = 64'd5; Px = 64'd3; Py = 64'd2; n = 64'd7;
        privateKey = 128'd3; counter = 128'd1; nonce = 128'h55;
        publicKeyX = {64'hDEAD_BEEF_0000_0001, 64'd6};
        publicKeyY = {64'hFEED_0000_0000_0002, 64'd5};

        // Reset
        repeat (3) tick();
        chk("rst_ready", {enc_ready, dec_ready}, 2'b11);
        chk("rst_ctrl", {enc_kdf_hashGo, dec_kdf_hashGo, enc_hash_go, dec_hash_go, enc_go, dec_go,
                         encrypter_done, decrypter_done, enc_valid, dec_valid, key_done}, 11'h0);
        chk("rst_data", {enc_key, dec_key, messageOutput, encrypt_kdf_req}, '0);
        rst = 1'b1;

        // Encrypt
        encrypter_go = 1'b1;
        tick();
        chk("enc_kdf_req", encrypt_kdf_req, REQ);
        chk("enc_kdf_go", enc_kdf_hashGo, 1'b1);
        enc_kdf_hashDone = 1'b1;
        tick();
        enc_kdf_hashDone = 1'b0;
        chk("enc_key", enc_key, 128'h12C);
        chk("enc_aes", {enc_go, enc_messageToProcess, key_done}, {1'b1, 32'd8, 1'b1});
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("enc_mac_go", {enc_hash_go, enc_go}, 2'b10);
        enc_hash_done = 1'b1;
        tick();
        enc_hash_done = 1'b0;
        chk("enc_done", {encrypter_done, enc_valid, enc_go}, 3'b110);
        chk("enc_tag", hashedMessage, 512'd2);

        // Decrypt with matching tag
        decrypter_go = 1'b1;
        tick();
        chk("dec_kdf_req", {decrypt_kdf_req, dec_kdf_hashGo}, {REQ, 1'b1});
        dec_kdf_hashDone = 1'b1;
        tick();
        dec_kdf_hashDone = 1'b0;
        chk("dec_key", dec_key, 128'h12C);
        chk("dec_mac_go", dec_hash_go, 1'b1);
        dec_hash_done = 1'b1;
        tick();
        dec_hash_done = 1'b0;
        chk("dec_aes", {dec_go, dec_messageToProcess}, {1'b1, 32'hC0DE_0008});
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        chk("dec_ok", {messageOutput, decrypter_done, dec_valid}, {32'd8, 2'b11});
        decrypter_go = 1'b0;
        tick();
        chk("dec_idle", {dec_ready, decrypter_done}, 2'b10);

        // Tag mismatch with all handshakes already high
        dec_kdf_hashDone = 1'b1; dec_hash_done = 1'b1; dec_done = 1'b1;
        dec_hashedMessage = 512'd3; messageReturn = 32'd9;
        decrypter_go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mm_no_dec_go", dec_go, 1'b0);
        end
        chk("mm_done", {decrypter_done, dec_valid, messageOutput}, {2'b10, 32'd8});
        decrypter_go = 1'b0;
        tick();

        // Decrypt minimum latency: success four cycles after go
        dec_hashedMessage = 512'd2;
        decrypter_go = 1'b1;
        repeat (3) tick();
        chk("dec_lat3", decrypter_done, 1'b0);
        tick();
        chk("dec_lat4", {decrypter_done, dec_valid, messageOutput}, {2'b11, 32'd9});
        decrypter_go = 1'b0;
        dec_kdf_hashDone = 1'b0; dec_hash_done = 1'b0; dec_done = 1'b0;
        tick();

        // Encrypt minimum latency
        encrypter_go = 1'b0;
        tick();
        enc_kdf_hashDone = 1'b1; enc_done = 1'b1; enc_hash_done = 1'b1;
        encrypter_go = 1'b1;
        repeat (3) tick();
        chk("enc_lat3", encrypter_done, 1'b0);
        tick();
        chk("enc_lat4", {encrypter_done, enc_valid}, 2'b11);
        encrypter_go = 1'b0;
        enc_kdf_hashDone = 1'b0; enc_done = 1'b0; enc_hash_done = 1'b0;
        tick();

        // Hasher stall in KDF
        hash_ready = 1'b0;
        encrypter_go = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_go_low", enc_kdf_hashGo, 1'b0);
            tick();
        end
        hash_ready = 1'b1;
        #1;
        chk("stall_go_high", enc_kdf_hashGo, 1'b1);
        enc_kdf_hashDone = 1'b1;
        tick();
        enc_kdf_hashDone = 1'b0;
        chk("stall_aes", enc_go, 1'b1);

        // Reset mid-AES, then decrypt with no stored record
        rst = 1'b0;
        encrypter_go = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort", {enc_ready, enc_go, enc_key, hashedMessage, messageOutput},
            {2'b10, 128'h0, 512'h0, 32'h0});
        decrypter_go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("norec", {dec_ready, dec_kdf_hashGo, decrypt_kdf_req}, {2'b10, 80'h0});
        end
        decrypter_go = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
